// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light sequencer and its display driver.
package traffic_pkg;

    localparam logic [1:0] PH_OFF   = 2'b00;
    localparam logic [1:0] PH_LEFT  = 2'b01;
    localparam logic [1:0] PH_FWD   = 2'b10;
    localparam logic [1:0] PH_RIGHT = 2'b11;

    localparam int unsigned LAMP_LEFT   = 0;
    localparam int unsigned LAMP_FWD    = 1;
    localparam int unsigned LAMP_RIGHT  = 2;
    localparam int unsigned LAMP_YELLOW = 3;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {StIdle, StShift, StDone} conv_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/traffic_display_driver_if.sv
// Sequencer-to-display bundle: phase/count in, lamp and display drives out.
interface traffic_display_driver_if;
    logic [1:0]  phase;
    logic [31:0] count;
    logic [3:0]  lamp;
    logic [6:0]  seg;
    logic [1:0]  an;
    logic [3:0]  bcd_tens;
    logic [3:0]  bcd_ones;
    logic        conv_busy;

    modport master (
        output phase, count,
        input  lamp, seg, an, bcd_tens, bcd_ones, conv_busy
    );

    modport slave (
        input  phase, count,
        output lamp, seg, an, bcd_tens, bcd_ones, conv_busy
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 7-bit binary to two-digit BCD converter (shift-add-3, 7 iterations).
module bin2bcd_seq
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [6:0] value_i,
    output logic       busy_o,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    conv_state_e state_q;
    logic [14:0] sr_q;
    logic [14:0] sr_adj;
    logic [2:0]  iter_q;
    logic        busy_q;
    logic [3:0]  tens_q;
    logic [3:0]  ones_q;

    always_comb begin
        sr_adj = sr_q;
        if (sr_q[10:7] >= 4'd5) sr_adj[10:7] = sr_q[10:7] + 4'd3;
        if (sr_q[14:11] >= 4'd5) sr_adj[14:11] = sr_q[14:11] + 4'd3;
    end

    // A new start aborts any conversion in flight; results only land in StDone.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            sr_q    <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            tens_q  <= '0;
            ones_q  <= '0;
        end else if (start_i) begin
            state_q <= StShift;
            sr_q    <= {8'd0, value_i};
            iter_q  <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                StShift: begin
                    sr_q <= {sr_adj[13:0], 1'b0};
                    if (iter_q == 3'd6) state_q <= StDone;
                    else                iter_q  <= iter_q + 3'd1;
                end
                StDone: begin
                    tens_q  <= sr_q[14:11];
                    ones_q  <= sr_q[10:7];
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign tens_o = tens_q;
    assign ones_o = ones_q;

endmodule

// File: rtl/traffic_display_driver.sv
// Lamp decode, change-triggered BCD conversion and two-digit multiplexed display.
module traffic_display_driver
    import traffic_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned SAT_MAX  = 99
) (
    input logic                     clk,
    input logic                     reset,
    traffic_display_driver_if.slave bus
);

    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);

    logic [31:0]      count_q;
    logic [ScanW-1:0] scan_q, scan_d;
    logic [1:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       lamp_q, lamp_d;
    logic             change;
    logic             stopped;
    logic [6:0]       sat_val;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;
    logic             conv_busy;

    assign change  = (bus.count != count_q);
    assign stopped = (bus.phase == PH_OFF) && (bus.count == 32'd0);
    assign sat_val = (bus.count > SAT_MAX) ? 7'(SAT_MAX) : bus.count[6:0];

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (change),
        .value_i (sat_val),
        .busy_o  (conv_busy),
        .tens_o  (bcd_tens),
        .ones_o  (bcd_ones)
    );

    always_comb begin
        lamp_d = '0;
        case (bus.phase)
            PH_LEFT:  lamp_d[LAMP_LEFT]  = 1'b1;
            PH_FWD:   lamp_d[LAMP_FWD]   = 1'b1;
            PH_RIGHT: lamp_d[LAMP_RIGHT] = 1'b1;
            default:  lamp_d[LAMP_YELLOW] = (bus.count != 32'd0);
        endcase
    end

    // seg is computed for the digit selected next so seg and an move together.
    always_comb begin
        scan_d = (scan_q == ScanLast) ? '0 : scan_q + ScanW'(1);
        an_d   = (scan_q == ScanLast) ? ~an_q : an_q;
        if (stopped)                          seg_d = SEG_BLANK;
        else if (an_d == 2'b01)               seg_d = (bcd_tens == 4'd0) ? SEG_BLANK
                                                                         : seg_decode(bcd_tens);
        else                                  seg_d = seg_decode(bcd_ones);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            scan_q  <= '0;
            an_q    <= 2'b10;
            seg_q   <= SEG_BLANK;
            lamp_q  <= '0;
        end else begin
            count_q <= bus.count;
            scan_q  <= scan_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            lamp_q  <= lamp_d;
        end
    end

    assign bus.lamp      = lamp_q;
    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.bcd_tens  = bcd_tens;
    assign bus.bcd_ones  = bcd_ones;
    assign bus.conv_busy = conv_busy;

endmodule

// File: tb/tb_traffic_display_driver.sv
// Directed bench for traffic_display_driver; conversion results checked by a scoreboard monitor.
module tb_traffic_display_driver;

    typedef struct {
        logic [3:0] tens;
        logic [3:0] ones;
        int         len;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total = 0;
    exp_t exp_q[$];

    traffic_display_driver_if bus ();

    traffic_display_driver #(
        .SCAN_DIV (4),
        .SAT_MAX  (99)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) $display("FAIL %s: got %0h, required %0h", name, act, req);
        else             passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_conv(input logic [3:0] t, input logic [3:0] o, input int len);
        exp_t e;
        e.tens = t;
        e.ones = o;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    // Monitor: a falling conv_busy outside reset is a completed conversion.
    logic busy_prev = 1'b0;
    int   busy_len = 0;
    always @(negedge clk) begin
        if (reset) begin
            busy_prev = 1'b0;
            busy_len  = 0;
        end else begin
            if (bus.conv_busy) busy_len++;
            if (busy_prev && !bus.conv_busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_conv", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("conv_tens", 32'(bus.bcd_tens), 32'(e.tens));
                    check("conv_ones", 32'(bus.bcd_ones), 32'(e.ones));
                    check("conv_busy_len", busy_len, e.len);
                end
                busy_len = 0;
            end
            busy_prev = bus.conv_busy;
        end
    end

    initial begin
        int   seg_err;
        int   last_t;
        int   toggles;
        logic [1:0] prev_an;
        logic found;

        // Reset with phase=FWD, count=15
        bus.phase = 2'b10;
        bus.count = 32'd15;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_lamp", 32'(bus.lamp), 32'h0);
            check("rst_seg", 32'(bus.seg), 32'h7F);
            check("rst_an", 32'(bus.an), 32'h2);
            check("rst_bcd", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h00);
            check("rst_busy", 32'(bus.conv_busy), 32'h0);
        end
        reset = 1'b0;
        expect_conv(4'd1, 4'd5, 8);
        tick();
        check("lamp_fwd", 32'(bus.lamp), 32'h2);
        check("busy_start", 32'(bus.conv_busy), 32'h1);
        for (int i = 0; i < 7; i++) tick();
        check("bcd_hold_n7", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h00);
        tick();
        check("bcd_15", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h15);
        check("busy_end", 32'(bus.conv_busy), 32'h0);

        // count=7, phase=LEFT, scan behaviour
        bus.phase = 2'b01;
        bus.count = 32'd7;
        expect_conv(4'd0, 4'd7, 8);
        for (int i = 0; i < 10; i++) tick();
        check("lamp_left", 32'(bus.lamp), 32'h1);
        check("bcd_7", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h07);
        seg_err = 0;
        last_t  = -1;
        toggles = 0;
        prev_an = bus.an;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (bus.an !== prev_an) begin
                toggles++;
                if (last_t >= 0) check("scan_gap", t - last_t, 4);
                last_t = t;
            end
            prev_an = bus.an;
            if (bus.an == 2'b10 && bus.seg !== 7'h78) seg_err++;
            else if (bus.an == 2'b01 && bus.seg !== 7'h7F) seg_err++;
            else if (bus.an != 2'b10 && bus.an != 2'b01) seg_err++;
        end
        check("scan_seg", seg_err, 0);
        check("scan_toggles", toggles, 5);

        // Saturation
        bus.phase = 2'b10;
        bus.count = 32'd250;
        expect_conv(4'd9, 4'd9, 8);
        for (int i = 0; i < 9; i++) tick();
        check("bcd_sat250", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h99);
        bus.count = 32'd100;
        expect_conv(4'd9, 4'd9, 8);
        for (int i = 0; i < 9; i++) tick();
        check("bcd_sat100", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h99);
        bus.count = 32'd99;
        expect_conv(4'd9, 4'd9, 8);
        for (int i = 0; i < 9; i++) tick();
        bus.count = 32'd250;
        expect_conv(4'd9, 4'd9, 8);
        tick();
        check("busy_same_sat", 32'(bus.conv_busy), 32'h1);
        for (int i = 0; i < 8; i++) tick();
        check("bcd_99_250", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h99);

        // Abort: 10 -> 9 at N, 9 -> 8 at N+3
        bus.count = 32'd10;
        expect_conv(4'd1, 4'd0, 8);
        for (int i = 0; i < 10; i++) tick();
        check("bcd_10", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h10);
        bus.count = 32'd9;
        seg_err = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.seg === 7'h10) seg_err++;
        end
        bus.count = 32'd8;
        expect_conv(4'd0, 4'd8, 11);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.seg === 7'h10) seg_err++;
            if ({bus.bcd_tens, bus.bcd_ones} !== 8'h10) seg_err++;
        end
        check("abort_hold_no9", seg_err, 0);
        tick();
        check("bcd_8_abort", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h08);
        check("busy_after_abort", 32'(bus.conv_busy), 32'h0);

        // Yellow with count=3, then stopped
        bus.phase = 2'b00;
        bus.count = 32'd3;
        expect_conv(4'd0, 4'd3, 8);
        for (int i = 0; i < 10; i++) tick();
        check("lamp_yellow", 32'(bus.lamp), 32'h8);
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!found && bus.an == 2'b10) begin
                check("seg_ones_3", 32'(bus.seg), 32'h30);
                found = 1'b1;
            end
        end
        check("ones_seen", 32'(found), 32'h1);
        bus.count = 32'd0;
        expect_conv(4'd0, 4'd0, 8);
        for (int i = 0; i < 10; i++) tick();
        check("lamp_stopped", 32'(bus.lamp), 32'h0);
        seg_err = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.seg !== 7'h7F) seg_err++;
        end
        check("stopped_blank", seg_err, 0);

        // Reset during SHIFT
        bus.phase = 2'b10;
        bus.count = 32'd56;
        expect_conv(4'd5, 4'd6, 8);
        for (int i = 0; i < 10; i++) tick();
        check("bcd_56", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h56);
        bus.count = 32'd42;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        bus.count = 32'd37;
        tick();
        check("rst_mid_busy", 32'(bus.conv_busy), 32'h0);
        check("rst_mid_bcd", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h00);
        reset = 1'b0;
        expect_conv(4'd3, 4'd7, 8);
        for (int i = 0; i < 10; i++) tick();
        check("bcd_37", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h37);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/traffic_display_driver.md
Name: traffic_display_driver

Overview:
Downstream stage of the traffic-light sequencer. It consumes the sequencer's 2-bit phase code and 32-bit countdown value, and produces two sets of registered outputs: one-hot lamp drives, and a two-digit multiplexed 7-segment countdown display. The binary-to-BCD conversion is sequential (shift-add-3), so the block has a small FSM, a scan divider and handshake-free change detection.

Parameters:
SCAN_DIV, 50000, clk cycles each digit is enabled before the scan toggles to the other digit (minimum 2)
SAT_MAX, 99, largest value shown; inputs above this are clamped to it

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
phase  in  2  sequencer phase: 00 OFF/yellow, 01 LEFT, 10 FORWARD, 11 RIGHT
count  in  32  sequencer countdown value (seconds remaining)
lamp  out  4  {yellow, right, forward, left}, active-high, one-hot or zero
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
an  out  2  digit enables {tens, ones}, active-low
bcd_tens  out  4  last converted tens digit
bcd_ones  out  4  last converted ones digit
conv_busy  out  1  high while a conversion is in progress

Behaviour:
- One clock domain. clk and reset only; reset is synchronous and active-high and wins over all other activity.
- Reset values:
  - lamp=0000, seg=7'h7F, an=2'b10 (ones digit selected)
  - bcd_tens=0, bcd_ones=0, conv_busy=0
  - scan counter=0, FSM=IDLE, latched count=0
- Lamp decode, registered with 1-cycle latency:
  - 01 -> 0001, 10 -> 0010, 11 -> 0100
  - 00 with count!=0 -> 1000
  - 00 with count==0 -> 0000 (stopped)
- Saturation: value = (count > SAT_MAX) ? SAT_MAX : count[6:0]. The comparison uses all 32 bits.
- Change detection: a register holds the last accepted count. Any cycle where count differs from it triggers a conversion start.
- FSM states and transitions:
  - IDLE: on a change, latch count, load the 7-bit saturated value plus a zeroed 8-bit BCD field, set conv_busy=1, go to SHIFT with iteration counter=0.
  - SHIFT: each cycle, first add 3 to any BCD nibble >= 5, then shift left 1. After the 7th shift go to DONE.
  - DONE: write bcd_tens/bcd_ones, clear conv_busy, return to IDLE.
- Conversion latency: the count change is seen at edge N. SHIFT runs N+1..N+7. bcd_* update at edge N+8. conv_busy is high from N+1 through N+8 and low again after edge N+8.
- Change mid-conversion: the conversion in progress is aborted. The new value is latched and the FSM restarts at iteration 0 on that edge. bcd_* hold their old value until a conversion completes.
- Display holds the last completed bcd_* while a conversion runs, so no glitches appear on the display.
- Scan timing:
  - The scan counter runs 0..SCAN_DIV-1 and wraps.
  - On wrap, an toggles between 2'b10 (ones) and 2'b01 (tens).
  - seg is registered together with an, so both change on the same edge.
- Digit content and blanking:
  - Tens digit is blanked (seg=7'h7F) when bcd_tens==0 (leading-zero blanking).
  - Both digits are blanked when the stopped condition holds (phase==00 and count==0).
  - Ones digit shows 0..9 with standard active-low patterns, e.g. 0=7'h40, 1=7'h79, 9=7'h10.
- Non-decimal BCD (values >9) cannot occur. The decoder's default is blank.

Decomposition:
- Shared package traffic_pkg:
  - phase encodings PH_OFF/PH_LEFT/PH_FWD/PH_RIGHT, the same codes the sequencer uses
  - lamp bit indices
  - 7-segment digit constants and the blank pattern
  - FSM state typedef {IDLE, SHIFT, DONE}
- One natural sub-module: bin2bcd_seq. It contains the FSM, shift register and iteration counter, with start/value in and busy/tens/ones out.
- The scan divider, segment decode and lamp decode stay in the top-level module.

Test Plan:
- Reset with phase=10, count=15: hold reset 3 cycles and release. During reset all outputs equal their reset values. Lamp=0010 one cycle after release. bcd=1/5 at release edge+8. conv_busy is high for exactly 8 cycles.
- SCAN_DIV=4, count=7, phase=01: after conversion, an alternates 10/01 every 4 cycles. The ones digit drives 7'h78 and the tens digit is blank (7'h7F). lamp=0001.
- count=250 then count=100: each gives bcd=9/9 (saturation). A step from 99 to 250 (same saturated value) still triggers a conversion, because count itself changed, and the result stays 9/9.
- count changes 10 -> 9 at edge N, then 9 -> 8 at edge N+3: conversion restarts at N+3, bcd=0/8 at N+11, and bcd=1/0 holds until then. A value of 9 is never displayed.
- phase=00, count=3 -> lamp=1000 and the ones digit shows 7'h30. Then phase=00, count=0 -> lamp=0000 and both digits are blank.
- Assert reset during SHIFT: on the next edge conv_busy=0 and bcd=0/0, and the previously pending conversion never completes.
